// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: bubble word, reset PC default
// and the fetch-stage state encoding.
package cpu_pkg;

  // addi x0,x0,0 -- harmless because it writes x0.
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory and decode.
// Decode side: PCsrc/reg_jump/ImmExt/ALUresult/stall in, Instr/PC_D/PCPlus4_D/valid_D out.
// Memory side: imem_req/imem_addr out, imem_rdata/imem_ack in.
interface fetch_stage_if;
  logic        PCsrc;
  logic        reg_jump;
  logic [31:0] ImmExt;
  logic [31:0] ALUresult;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Instr;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic        valid_D;

  // Fetch stage side.
  modport master (
    input  PCsrc, reg_jump, ImmExt, ALUresult, stall, imem_rdata, imem_ack,
    output imem_req, imem_addr, Instr, PC_D, PCPlus4_D, valid_D
  );

  // Environment side (decode + instruction memory).
  modport slave (
    output PCsrc, reg_jump, ImmExt, ALUresult, stall, imem_rdata, imem_ack,
    input  imem_req, imem_addr, Instr, PC_D, PCPlus4_D, valid_D
  );
endinterface

// File: rtl/next_pc.sv
// Combinational next-PC arithmetic: redirect target, sequential PC+4 and PC_D+4.
// Latency: 0 (pure combinational).  Backpressure: none, no state.
// Ports: i_pc/i_pc_d/i_imm/i_alu/i_reg_jump in; o_target/o_pc_plus4/o_pc_d_plus4 out.
module next_pc (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_d,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_alu,
  input  logic        i_reg_jump,
  output logic [31:0] o_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_pc_d_plus4
);

  logic [31:0] w_raw_target;

  // JALR clears bit 0 of the register result; branches/JAL are PC-relative.
  assign w_raw_target = i_reg_jump ? {i_alu[31:1], 1'b0} : (i_pc_d + i_imm);

  // The PC only ever holds word addresses, so strip the byte offset here.
  assign o_target     = w_raw_target & ~32'd3;
  assign o_pc_plus4   = i_pc + 32'd4;
  assign o_pc_d_plus4 = i_pc_d + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem req/ack fetches, fills the fetch->decode register.
// Latency: fetched word is on Instr the cycle after imem_ack; one instr/cycle with zero-wait memory.
// Backpressure: stall freezes the decode register; a word landing during stall waits in a 1-deep skid.
// Ports: clk, rst (async, active-high); bus = fetch_stage_if.master (decode + imem signals).
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_pc;        // address of the word being (or next to be) fetched
  logic [31:0] r_drain_pc;  // address of the request orphaned by a redirect
  logic [31:0] r_skid;      // word captured while decode was stalled (valid in HOLD)
  logic [31:0] r_instr;
  logic [31:0] r_pc_d;
  logic        r_valid_d;

  logic        w_in_req;
  logic        w_ack;
  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_d_plus4;

  next_pc u_next_pc (
    .i_pc         (r_pc),
    .i_pc_d       (r_pc_d),
    .i_imm        (bus.ImmExt),
    .i_alu        (bus.ALUresult),
    .i_reg_jump   (bus.reg_jump),
    .o_target     (w_target),
    .o_pc_plus4   (w_pc_plus4),
    .o_pc_d_plus4 (w_pc_d_plus4)
  );

  assign w_in_req = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  // An ack with no request outstanding (IDLE/HOLD) is not ours to consume.
  assign w_ack    = bus.imem_ack & w_in_req;
  // A stalled redirect stays pending in decode and is re-presented later.
  assign w_redir  = bus.PCsrc & r_valid_d & ~bus.stall;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ----------------------------------------------------------- FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (w_redir) begin
          // Without an ack the old request is still in flight and must be drained.
          w_state_nxt = w_ack ? ST_FETCH : ST_DRAIN;
        end else if (w_ack && bus.stall) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Either the buffered word moves on or a redirect discards it.
        if (!bus.stall) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (w_ack) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- FSM output
  always_comb begin
    bus.imem_req  = w_in_req;
    bus.imem_addr = ((r_state == ST_DRAIN) ? r_drain_pc : r_pc) & ~32'd3;
  end

  // ----------------------------------------------- PC, skid and decode register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_drain_pc <= RESET_PC;
      r_skid     <= NOP;
      r_instr    <= NOP;
      r_pc_d     <= 32'd0;
      r_valid_d  <= 1'b0;
    end else if (w_redir) begin
      r_pc      <= w_target;
      r_instr   <= NOP;
      r_valid_d <= 1'b0;
      if ((r_state == ST_FETCH) && !w_ack) begin
        r_drain_pc <= r_pc;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_ack && !bus.stall) begin
            r_instr   <= bus.imem_rdata;
            r_pc_d    <= r_pc;
            r_valid_d <= 1'b1;
            r_pc      <= w_pc_plus4;
          end else if (w_ack) begin
            r_skid <= bus.imem_rdata;
          end else if (!bus.stall) begin
            r_instr   <= NOP;
            r_valid_d <= 1'b0;
          end
        end
        ST_HOLD: begin
          // PC was not advanced at capture time, so it still names the skid word.
          if (!bus.stall) begin
            r_instr   <= r_skid;
            r_pc_d    <= r_pc;
            r_valid_d <= 1'b1;
            r_pc      <= w_pc_plus4;
          end
        end
        default: begin
          // IDLE/DRAIN deliver nothing: decode sees a bubble once it moves on.
          if (!bus.stall) begin
            r_instr   <= NOP;
            r_valid_d <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.Instr     = r_instr;
  assign bus.PC_D      = r_pc_d;
  assign bus.PCPlus4_D = w_pc_d_plus4;
  assign bus.valid_D   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed per-cycle vector table, reset-during-drain sequence,
// then random stall/latency/redirect traffic checked against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP      (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ------------------------------------------------ instruction memory model
  int   lat       = 0;     // ack arrives once a request has waited lat cycles
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_comb begin
    bus.imem_ack   = force_ack | (bus.imem_req && (wait_cnt >= lat));
    bus.imem_rdata = mem_word(bus.imem_addr);
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                              wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else                                  wait_cnt <= 0;
  end

  // ------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic        rj;
    logic [31:0] imm;
    logic [31:0] alu;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pcd;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic st, input logic ps, input logic rj, input logic [31:0] imm,
                     input logic [31:0] alu, input int l, input logic req, input logic [31:0] addr,
                     input logic vld, input logic [31:0] pcd);
    vec_t v;
    v.stall = st; v.pcsrc = ps; v.rj = rj; v.imm = imm; v.alu = alu; v.lat = l;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_pcd = pcd;
    tv.push_back(v);
  endtask

  task automatic drive(input logic st, input logic ps, input logic rj,
                       input logic [31:0] imm, input logic [31:0] alu, input int l);
    bus.stall = st; bus.PCsrc = ps; bus.reg_jump = rj;
    bus.ImmExt = imm; bus.ALUresult = alu; lat = l;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_vld"},   {31'd0, bus.valid_D},  32'd0);
    chk({tag, "_instr"}, bus.Instr,             NOP);
    chk({tag, "_pcd"},   bus.PC_D,              32'd0);
    chk({tag, "_pcp4"},  bus.PCPlus4_D,         32'd4);
  endtask

  // random-phase state
  logic [31:0] exp_pc;
  logic [31:0] tgt;
  logic [31:0] a;
  logic [31:0] prev_addr;
  logic        prev_pending;
  int          consumed;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);

    // Cycle-by-cycle vectors (cycle 0 = first cycle after reset release).
    //   stall ps rj imm           alu           lat | req addr         vld pcd
    add(0,0,0,32'd0,0,0,            0,32'h00,0,32'h00);
    add(0,0,0,32'd0,0,0,            1,32'h00,0,32'h00);
    add(0,0,0,32'd0,0,0,            1,32'h04,1,32'h00);
    add(0,0,0,32'd0,0,0,            1,32'h08,1,32'h04);
    add(0,0,0,32'd0,0,0,            1,32'h0C,1,32'h08);
    add(0,0,0,32'd0,0,0,            1,32'h10,1,32'h0C);
    add(0,1,0,32'hFFFF_FFF0,0,0,    1,32'h14,1,32'h10);   // BEQ at 0x10 -> 0x0
    add(0,0,0,32'd0,0,0,            1,32'h00,0,32'h00);   // word for 0x14 dropped
    add(0,0,0,32'd0,0,0,            1,32'h04,1,32'h00);
    add(1,0,0,32'd0,0,0,            1,32'h08,1,32'h04);   // ack under stall -> skid
    add(1,0,0,32'd0,0,0,            0,32'h08,1,32'h04);
    add(1,0,0,32'd0,0,0,            0,32'h08,1,32'h04);
    add(1,0,0,32'd0,0,0,            0,32'h08,1,32'h04);
    add(0,0,0,32'd0,0,0,            0,32'h08,1,32'h04);   // stall falls
    add(0,0,0,32'd0,0,0,            1,32'h0C,1,32'h08);   // buffered word appears once
    add(0,0,0,32'd0,0,0,            1,32'h10,1,32'h0C);
    add(0,0,0,32'd0,0,2,            1,32'h14,1,32'h10);   // 3-cycle memory
    add(0,0,0,32'd0,0,2,            1,32'h14,0,32'h00);
    add(0,0,0,32'd0,0,2,            1,32'h14,0,32'h00);
    add(0,0,0,32'd0,0,2,            1,32'h18,1,32'h14);
    add(0,0,0,32'd0,0,2,            1,32'h18,0,32'h00);
    add(0,0,0,32'd0,0,2,            1,32'h18,0,32'h00);
    add(0,1,1,32'd0,32'h103,2,      1,32'h1C,1,32'h18);   // JALR while 0x1C outstanding
    add(0,0,0,32'd0,0,2,            1,32'h1C,0,32'h00);   // draining old address
    add(0,0,0,32'd0,0,2,            1,32'h1C,0,32'h00);
    add(0,0,0,32'd0,0,2,            1,32'h100,0,32'h00);
    add(0,0,0,32'd0,0,2,            1,32'h100,0,32'h00);
    add(0,0,0,32'd0,0,2,            1,32'h100,0,32'h00);
    add(0,0,0,32'd0,0,2,            1,32'h104,1,32'h100); // stale 0x1C word never valid

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stall, tv[i].pcsrc, tv[i].rj, tv[i].imm, tv[i].alu, tv[i].lat);
      #1;
      chk($sformatf("row%0d_req", i), {31'd0, bus.imem_req}, {31'd0, tv[i].e_req});
      if (tv[i].e_req) chk($sformatf("row%0d_addr", i), bus.imem_addr, tv[i].e_addr);
      chk($sformatf("row%0d_vld", i), {31'd0, bus.valid_D}, {31'd0, tv[i].e_vld});
      chk($sformatf("row%0d_instr", i), bus.Instr, tv[i].e_vld ? mem_word(tv[i].e_pcd) : NOP);
      if (tv[i].e_vld) begin
        chk($sformatf("row%0d_pcd", i),  bus.PC_D,      tv[i].e_pcd);
        chk($sformatf("row%0d_pcp4", i), bus.PCPlus4_D, tv[i].e_pcd + 32'd4);
      end
      @(negedge clk);
    end

    // Redirect into DRAIN, then reset while draining.
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0, 2);
    #1;
    chk("drain_pre_vld", {31'd0, bus.valid_D}, 32'd1);
    chk("drain_pre_pcd", bus.PC_D, 32'h104);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2);
    #1;
    chk("drain_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("drain_addr", bus.imem_addr, 32'h108);
    chk("drain_vld",  {31'd0, bus.valid_D}, 32'd0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_drain");
    force_ack = 1'b1;
    @(negedge clk);
    #1 chk_reset_outputs("rst_ack");
    @(negedge clk);
    rst = 1'b0; force_ack = 1'b0; lat = 0;
    #1 chk("restart_idle_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("restart_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("restart_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    #1;
    chk("restart_vld",   {31'd0, bus.valid_D}, 32'd1);
    chk("restart_pcd",   bus.PC_D, 32'h0);
    chk("restart_instr", bus.Instr, mem_word(32'h0));
    chk("restart_addr2", bus.imem_addr, 32'h4);

    // Random traffic against the program-order model: every instruction decode
    // accepts (valid_D & ~stall) must be the next one in architectural order.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0; prev_pending = 1'b0; prev_addr = 32'h0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      a = $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 63) << 2) - 32'd128, {a[31:2], 1'b0, a[0]},
            int'($urandom_range(0, 3)));
      #1;
      if (prev_pending) begin
        chk("rnd_req_held",  {31'd0, bus.imem_req}, 32'd1);
        chk("rnd_addr_held", bus.imem_addr, prev_addr);
      end
      if (bus.valid_D && !bus.stall) begin
        chk("rnd_pcd",   bus.PC_D,      exp_pc);
        chk("rnd_instr", bus.Instr,     mem_word(exp_pc));
        chk("rnd_pcp4",  bus.PCPlus4_D, exp_pc + 32'd4);
        tgt = bus.reg_jump ? (bus.ALUresult & ~32'd1) : (exp_pc + bus.ImmExt);
        exp_pc = bus.PCsrc ? tgt : exp_pc + 32'd4;
        consumed++;
      end else if (!bus.valid_D) begin
        chk("rnd_bubble_nop", bus.Instr, NOP);
      end
      prev_pending = bus.imem_req && !bus.imem_ack;
      prev_addr    = bus.imem_addr;
      @(negedge clk);
    end
    chk("rnd_progress", {31'd0, consumed >= 300}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
